// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Memory stage after the execute ALU. For each instruction it either runs a
//   single data-memory transaction (req/gnt/rvalid handshake) or passes the ALU
//   result through. It produces exactly one writeback result per instruction,
//   and keeps the execute stage stalled (ex_ready low) while it is busy.
//
// Ports
//   clk, rst_n         clock / asynchronous active-low reset
//   ex_valid/ex_ready  handshake with the execute stage (ready only in IDLE)
//   ex_alu_out         effective address for ld/st, otherwise the result value
//   ex_store_data      store source value
//   ex_is_load/store   operation kind (both set is illegal)
//   ex_funct3          access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ex_rd, ex_rd_we    destination register and its write enable
//   flush              kills the current or pending instruction
//   mem_*              data bus: req held until gnt, one outstanding access
//   wb_*               one-cycle writeback pulse with data / error code
//                      (01 misaligned, 10 illegal, 11 bus timeout)
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_store_data,
   input  logic        ex_is_load,
   input  logic        ex_is_store,
   input  logic [2:0]  ex_funct3,
   input  logic [4:0]  ex_rd,
   input  logic        ex_rd_we,
   input  logic        flush,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_we,
   output logic [31:0] wb_data,
   output logic        wb_err,
   output logic [1:0]  wb_err_code
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

   state_t      r_state;
   logic [31:0] r_addr;
   logic [31:0] r_cnt;
   logic [2:0]  r_f3;
   logic        r_is_store;
   logic        r_rd_ok;
   logic        r_flushed;

   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wstrb;
   logic        r_wb_valid;
   logic [4:0]  r_wb_rd;
   logic        r_wb_we;
   logic [31:0] r_wb_data;
   logic        r_wb_err;
   logic [1:0]  r_wb_code;

   logic        w_accept;
   logic        w_is_mem;
   logic        w_illegal;
   logic        w_misalign;
   logic [3:0]  w_strb;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_ld_data;
   logic [31:0] w_cnt_nxt;
   logic        w_timeout;
   logic        w_resp;
   logic        w_kill;

   assign w_accept  = ex_valid && (r_state == S_IDLE) && !flush;
   assign w_is_mem  = ex_is_load || ex_is_store;
   assign w_cnt_nxt = r_cnt + 32'd1;
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt >= LP_TIMEOUT);
   // a response only counts once the request has been (or is being) granted
   assign w_resp    = mem_rvalid && ((r_state == S_WAIT) || ((r_state == S_REQ) && mem_gnt));
   // a flush seen at any point after the grant still lets the bus finish
   assign w_kill    = r_flushed || flush;

   // Decode of the incoming instruction
   always_comb begin
      w_illegal = 1'b0;
      if (ex_is_load && ex_is_store)
         w_illegal = 1'b1;
      else if (ex_is_load)
         w_illegal = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
      else if (ex_is_store)
         w_illegal = ex_funct3[2] || (ex_funct3[1:0] == 2'b11);

      w_misalign = w_is_mem &&
                   (((ex_funct3[1:0] == 2'b01) && ex_alu_out[0]) ||
                    ((ex_funct3[1:0] == 2'b10) && (ex_alu_out[1:0] != 2'b00)));

      case (ex_funct3[1:0])
         2'b00: begin
            w_strb  = 4'b0001 << ex_alu_out[1:0];
            w_wdata = {4{ex_store_data[7:0]}};
         end
         2'b01: begin
            w_strb  = 4'b0011 << ex_alu_out[1:0];
            w_wdata = {2{ex_store_data[15:0]}};
         end
         default: begin
            w_strb  = 4'b1111;
            w_wdata = ex_store_data;
         end
      endcase
   end

   // Load data alignment and extension
   always_comb begin
      w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};
      case (r_f3)
         3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_ld_data = {24'h0, w_shifted[7:0]};
         3'b101:  w_ld_data = {16'h0, w_shifted[15:0]};
         default: w_ld_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_f3        <= '0;
         r_is_store  <= 1'b0;
         r_rd_ok     <= 1'b0;
         r_flushed   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_we     <= 1'b0;
         r_wb_data   <= '0;
         r_wb_err    <= 1'b0;
         r_wb_code   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr     <= ex_alu_out;
                  r_f3       <= ex_funct3;
                  r_is_store <= ex_is_store;
                  r_rd_ok    <= ex_rd_we && (ex_rd != 5'd0);
                  r_wb_rd    <= ex_rd;
                  r_cnt      <= '0;
                  r_flushed  <= 1'b0;
                  if (w_illegal || w_misalign) begin
                     r_state    <= S_DONE;
                     r_wb_valid <= 1'b1;
                     r_wb_we    <= 1'b0;
                     r_wb_err   <= 1'b1;
                     r_wb_code  <= w_illegal ? 2'b10 : 2'b01;
                     r_wb_data  <= ex_alu_out;
                  end else if (w_is_mem) begin
                     r_state     <= S_REQ;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= ex_is_store;
                     r_mem_addr  <= {ex_alu_out[31:2], 2'b00};
                     r_mem_wdata <= w_wdata;
                     r_mem_wstrb <= w_strb;
                  end else begin
                     r_state    <= S_DONE;
                     r_wb_valid <= 1'b1;
                     r_wb_we    <= ex_rd_we && (ex_rd != 5'd0);
                     r_wb_err   <= 1'b0;
                     r_wb_code  <= 2'b00;
                     r_wb_data  <= ex_alu_out;
                  end
               end
            end

            S_REQ, S_WAIT: begin
               r_cnt <= w_cnt_nxt;
               if (w_resp) begin
                  r_mem_req <= 1'b0;
                  if (w_kill) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state    <= S_DONE;
                     r_wb_valid <= 1'b1;
                     r_wb_we    <= !r_is_store && r_rd_ok;
                     r_wb_err   <= 1'b0;
                     r_wb_code  <= 2'b00;
                     r_wb_data  <= r_is_store ? '0 : w_ld_data;
                  end
               end else if ((r_state == S_REQ) && flush && !mem_gnt) begin
                  // request never granted: withdraw it silently
                  r_mem_req <= 1'b0;
                  r_state   <= S_IDLE;
               end else if (w_timeout) begin
                  r_mem_req <= 1'b0;
                  if (w_kill) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state    <= S_DONE;
                     r_wb_valid <= 1'b1;
                     r_wb_we    <= 1'b0;
                     r_wb_err   <= 1'b1;
                     r_wb_code  <= 2'b11;
                     r_wb_data  <= r_addr;
                  end
               end else begin
                  if ((r_state == S_REQ) && mem_gnt) begin
                     r_mem_req <= 1'b0;
                     r_state   <= S_WAIT;
                  end
                  if (flush)
                     r_flushed <= 1'b1;
               end
            end

            S_DONE: begin
               r_wb_valid <= 1'b0;
               r_state    <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ex_ready    = (r_state == S_IDLE);
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign mem_wstrb   = r_mem_wstrb;
   // a flush during the DONE cycle must still cancel the pulse
   assign wb_valid    = r_wb_valid && !flush;
   assign wb_rd       = r_wb_rd;
   assign wb_we       = r_wb_we;
   assign wb_data     = r_wb_data;
   assign wb_err      = r_wb_err;
   assign wb_err_code = r_wb_code;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed and randomized checks of load_store_unit against a behavioural
//   model of the memory stage. Inputs change and outputs are sampled on the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_alu_out;
   logic [31:0] ex_store_data;
   logic        ex_is_load;
   logic        ex_is_store;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd;
   logic        ex_rd_we;
   logic        flush;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_we;
   logic [31:0] wb_data;
   logic        wb_err;
   logic [1:0]  wb_err_code;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_out(ex_alu_out),
      .ex_store_data(ex_store_data), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
      .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
      .wb_err(wb_err), .wb_err_code(wb_err_code)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Behavioural model: sizes in bytes, byte lanes and integer sign extension.
   function automatic void model(
      input  logic ld, input logic st, input logic [2:0] f3,
      input  logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
      input  logic [4:0] rd, input logic rdwe,
      output bit bus, output logic err, output logic [1:0] code, output logic we,
      output logic [31:0] data, output logic [3:0] strb, output logic [31:0] wdata);
      int     nb;
      int     off;
      bit     legal;
      longint v;
      nb  = 1 << f3[1:0];
      off = int'(addr % 4);
      bus = 0; err = 0; code = 0; we = 0; data = 0; strb = 0; wdata = 0;
      if (!ld && !st) begin
         data = addr;
         we   = rdwe && (rd != 0);
         return;
      end
      if (ld && st)  legal = 0;
      else if (ld)   legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      else           legal = (f3 <= 2);
      if (!legal) begin
         err = 1; code = 2; data = addr;
         return;
      end
      if ((off % nb) != 0) begin
         err = 1; code = 1; data = addr;
         return;
      end
      bus  = 1;
      strb = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++)
         wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
      if (st)
         return;
      v = 0;
      for (int k = 0; k < nb; k++)
         v += longint'(rdata[8*(off+k) +: 8]) << (8*k);
      if (!f3[2] && (nb < 4) && (v >= (longint'(1) << (8*nb - 1))))
         v -= longint'(1) << (8*nb);
      data = v[31:0];
      we   = rdwe && (rd != 0);
   endfunction

   // Issue one instruction at the current falling edge, act as the bus slave
   // with the given grant / response delays, check the writeback, and return
   // on the falling edge where the stage is ready again.
   task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic rdwe, input int gd, input int rv);
      bit          e_bus;
      logic        e_err, e_we;
      logic [1:0]  e_code;
      logic [31:0] e_data, e_wdata;
      logic [3:0]  e_strb;
      model(ld, st, f3, addr, sd, rdata, rd, rdwe, e_bus, e_err, e_code, e_we, e_data, e_strb, e_wdata);

      chk({tag, ":ready_before"}, 32'(ex_ready), 32'd1);
      ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
      ex_alu_out = addr; ex_store_data = sd; ex_rd = rd; ex_rd_we = rdwe;
      @(negedge clk);
      ex_valid = 0; ex_alu_out = $urandom; ex_store_data = $urandom;
      chk({tag, ":ready_busy"}, 32'(ex_ready), 32'd0);

      if (e_bus) begin
         chk({tag, ":req"}, 32'(mem_req), 32'd1);
         chk({tag, ":addr"}, mem_addr, {addr[31:2], 2'b00});
         chk({tag, ":we"}, 32'(mem_we), 32'(st));
         if (st) begin
            chk({tag, ":wstrb"}, 32'(mem_wstrb), 32'(e_strb));
            chk({tag, ":wdata"}, mem_wdata, e_wdata);
         end
         repeat (gd) begin
            mem_rvalid = 1'($urandom);  // unrelated response before grant
            chk({tag, ":req_held"}, 32'(mem_req), 32'd1);
            @(negedge clk);
         end
         mem_gnt = 1; mem_rvalid = 0;
         if (rv == 0) begin mem_rvalid = 1; mem_rdata = rdata; end
         @(negedge clk);
         mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
         if (rv > 0) begin
            chk({tag, ":req_drop"}, 32'(mem_req), 32'd0);
            chk({tag, ":no_early_wb"}, 32'(wb_valid), 32'd0);
            repeat (rv - 1) @(negedge clk);
            mem_rvalid = 1; mem_rdata = rdata;
            @(negedge clk);
            mem_rvalid = 0; mem_rdata = $urandom;
         end
      end else begin
         chk({tag, ":no_req"}, 32'(mem_req), 32'd0);
      end

      chk({tag, ":wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ":wb_err"}, 32'(wb_err), 32'(e_err));
      chk({tag, ":wb_code"}, 32'(wb_err_code), 32'(e_code));
      chk({tag, ":wb_rd"}, 32'(wb_rd), 32'(rd));
      chk({tag, ":wb_we"}, 32'(wb_we), 32'(e_we));
      if (!(e_bus && st))
         chk({tag, ":wb_data"}, wb_data, e_data);
      @(negedge clk);
      chk({tag, ":wb_pulse_end"}, 32'(wb_valid), 32'd0);
      chk({tag, ":ready_after"}, 32'(ex_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic        r_ld, r_st;
      logic [31:0] r_addr;
      int          kind;

      rst_n = 0; ex_valid = 0; ex_alu_out = 0; ex_store_data = 0; ex_is_load = 0;
      ex_is_store = 0; ex_funct3 = 0; ex_rd = 0; ex_rd_we = 0; flush = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

      // reset values
      #12;
      chk("rst:ex_ready", 32'(ex_ready), 32'd1);
      chk("rst:mem_req", 32'(mem_req), 32'd0);
      chk("rst:mem_we", 32'(mem_we), 32'd0);
      chk("rst:mem_addr", mem_addr, 32'd0);
      chk("rst:mem_wdata", mem_wdata, 32'd0);
      chk("rst:mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst:wb_valid", 32'(wb_valid), 32'd0);
      chk("rst:wb_data", wb_data, 32'd0);
      chk("rst:wb_err", 32'(wb_err), 32'd0);
      chk("rst:wb_code", 32'(wb_err_code), 32'd0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // directed cases
      run_op("lb_sign", 1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 5'd7, 1, 0, 0);
      run_op("sh_lane", 0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 5'd9, 1, 1, 2);
      run_op("lw_misal", 1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 5'd4, 1, 0, 0);
      run_op("ld_f3_011", 1, 0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 5'd4, 1, 0, 0);
      run_op("ld_and_st", 1, 1, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 5'd4, 1, 0, 0);
      run_op("add", 0, 0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1, 0, 0);
      run_op("lbu", 1, 0, 3'b100, 32'h0000_0010, 32'h0, 32'h0000_00F0, 5'd6, 1, 0, 0);
      run_op("lh_rd0", 1, 0, 3'b001, 32'h0000_0042, 32'h0, 32'h8001_0000, 5'd0, 1, 2, 1);

      // bus timeout: grant never arrives
      ex_valid = 1; ex_is_load = 1; ex_is_store = 0; ex_funct3 = 3'b010;
      ex_alu_out = 32'h0000_0500; ex_rd = 5'd3; ex_rd_we = 1;
      @(negedge clk);
      ex_valid = 0;
      n = 0;
      while (mem_req === 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk("timeout:req_cycles", 32'(n), 32'd255);
      chk("timeout:wb_valid", 32'(wb_valid), 32'd1);
      chk("timeout:wb_err", 32'(wb_err), 32'd1);
      chk("timeout:wb_code", 32'(wb_err_code), 32'd3);
      chk("timeout:wb_data", wb_data, 32'h0000_0500);
      chk("timeout:wb_we", 32'(wb_we), 32'd0);
      @(negedge clk);
      chk("timeout:ready", 32'(ex_ready), 32'd1);
      // late response and stray grant in IDLE are ignored
      mem_rvalid = 1; mem_gnt = 1;
      @(negedge clk);
      mem_rvalid = 0; mem_gnt = 0;
      chk("late_rvalid:wb_valid", 32'(wb_valid), 32'd0);
      chk("late_rvalid:ready", 32'(ex_ready), 32'd1);

      // flush while waiting for the response
      ex_valid = 1; ex_is_load = 1; ex_is_store = 0; ex_funct3 = 3'b010; ex_alu_out = 32'h40;
      @(negedge clk);
      ex_valid = 0; mem_gnt = 1;
      @(negedge clk);
      mem_gnt = 0; flush = 1;
      @(negedge clk);
      flush = 0;
      repeat (2) begin
         chk("flush_wait:busy", 32'(ex_ready), 32'd0);
         chk("flush_wait:no_wb", 32'(wb_valid), 32'd0);
         @(negedge clk);
      end
      chk("flush_wait:busy", 32'(ex_ready), 32'd0);
      mem_rvalid = 1;
      @(negedge clk);
      mem_rvalid = 0;
      chk("flush_wait:ready", 32'(ex_ready), 32'd1);
      chk("flush_wait:no_wb", 32'(wb_valid), 32'd0);

      // flush before grant withdraws the request
      ex_valid = 1; ex_alu_out = 32'h80;
      @(negedge clk);
      ex_valid = 0;
      chk("flush_req:req", 32'(mem_req), 32'd1);
      flush = 1;
      @(negedge clk);
      flush = 0;
      chk("flush_req:req_drop", 32'(mem_req), 32'd0);
      chk("flush_req:ready", 32'(ex_ready), 32'd1);
      chk("flush_req:no_wb", 32'(wb_valid), 32'd0);

      // flush in IDLE blocks acceptance
      ex_valid = 1; ex_is_load = 0; flush = 1;
      @(negedge clk);
      ex_valid = 0; flush = 0;
      chk("flush_idle:ready", 32'(ex_ready), 32'd1);
      chk("flush_idle:no_wb", 32'(wb_valid), 32'd0);

      // flush during the DONE cycle cancels the pulse
      ex_valid = 1; ex_alu_out = 32'h55; ex_rd = 5'd2;
      @(negedge clk);
      ex_valid = 0; flush = 1;
      #1;
      chk("flush_done:no_wb", 32'(wb_valid), 32'd0);
      @(negedge clk);
      flush = 0;
      chk("flush_done:ready", 32'(ex_ready), 32'd1);

      // asynchronous reset in the middle of a request
      ex_valid = 1; ex_is_load = 1; ex_funct3 = 3'b000; ex_alu_out = 32'h99;
      @(negedge clk);
      ex_valid = 0;
      chk("rst_mid:req", 32'(mem_req), 32'd1);
      #2 rst_n = 0;
      #1;
      chk("rst_mid:req_low", 32'(mem_req), 32'd0);
      chk("rst_mid:ready", 32'(ex_ready), 32'd1);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // randomized instructions
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         r_ld = (kind >= 2 && kind <= 5) || (kind == 9);
         r_st = (kind >= 6);
         r_addr = $urandom;
         if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
         run_op($sformatf("rnd%0d", i), r_ld, r_st, 3'($urandom_range(0, 7)), r_addr,
                $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
